// File: rtl/dp_pkg.sv
// Shared types and helpers for the dot-product engine: FSM state encoding,
// a constant-width helper and the drain-length rule.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Multiplier stages plus the adder-tree and accumulator registers.
    function automatic int drain_cycles(input int mul_lat);
        return mul_lat + 2;
    endfunction

endpackage

// File: rtl/dp_mul_pipe.sv
// One lane: signed weight times zero-extended pixel, carried through
// MUL_LAT register stages together with its valid bit.
module dp_mul_pipe #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int MUL_LAT     = 2,
    localparam int PROD_W     = PIXEL_SIZE + WEIGHT_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   beat_valid,
    input  logic [PIXEL_SIZE-1:0]  pixel,
    input  logic [WEIGHT_SIZE-1:0] weight,
    output logic                   prod_valid,
    output logic [PROD_W-1:0]      product
);

    logic signed [PROD_W-1:0] full;
    logic [PROD_W-1:0]        stage_q [MUL_LAT];
    logic [MUL_LAT-1:0]       valid_q;

    // The true product always fits PROD_W signed bits, so no headroom is lost.
    assign full = $signed(weight) * $signed({1'b0, pixel});

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= beat_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q[0] <= full;
        for (int i = 1; i < MUL_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign prod_valid = valid_q[MUL_LAT-1];
    assign product    = stage_q[MUL_LAT-1];

endmodule

// File: rtl/dot_product_engine.sv
// Command-driven dot product: PARALLEL lanes per beat, vec_len beats per
// command, result held on a valid/ready output until taken.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int PARALLEL    = 2,
    parameter int MUL_LAT     = 2,
    parameter int LEN_W       = 8
) (
    input  logic                            clk,
    input  logic                            GlobalReset,
    input  logic                            start,
    input  logic [LEN_W-1:0]                vec_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels,
    input  logic [PARALLEL*WEIGHT_SIZE-1:0] Weights,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [VAL_SIZE-1:0]             value,
    output logic                            busy
);

    localparam int PROD_W    = PIXEL_SIZE + WEIGHT_SIZE;
    localparam int DRAIN_CYC = drain_cycles(MUL_LAT);
    localparam int DW        = clog2(DRAIN_CYC + 1);

    state_t                state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat_cnt;
    logic [DW-1:0]         drain_cnt;
    logic                  beat_acc;
    logic [PARALLEL-1:0]   lane_valid;
    logic [VAL_SIZE-1:0]   lane_val [PARALLEL];
    logic [VAL_SIZE-1:0]   tree_next;
    logic [VAL_SIZE-1:0]   tree_sum;
    logic                  tree_valid;
    logic [VAL_SIZE-1:0]   acc;

    assign beat_acc = in_valid & in_ready;

    // Bubbles enter the pipes with a cleared valid bit and never reach acc.
    for (genvar j = 0; j < PARALLEL; j++) begin : g_lane
        logic [PROD_W-1:0] prod;

        dp_mul_pipe #(
            .PIXEL_SIZE (PIXEL_SIZE),
            .WEIGHT_SIZE(WEIGHT_SIZE),
            .MUL_LAT    (MUL_LAT)
        ) u_mul (
            .clk       (clk),
            .rst       (GlobalReset),
            .beat_valid(beat_acc),
            .pixel     (Pixels[j*PIXEL_SIZE +: PIXEL_SIZE]),
            .weight    (Weights[j*WEIGHT_SIZE +: WEIGHT_SIZE]),
            .prod_valid(lane_valid[j]),
            .product   (prod)
        );

        // Signed size cast: truncates a wide product, sign-extends a narrow one.
        assign lane_val[j] = VAL_SIZE'($signed(prod));
    end

    always_comb begin
        tree_next = '0;
        for (int j = 0; j < PARALLEL; j++) begin
            tree_next = tree_next + lane_val[j];
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            tree_valid <= 1'b0;
            tree_sum   <= '0;
        end else begin
            tree_valid <= &lane_valid;
            tree_sum   <= tree_next;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            acc <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
        end else if (tree_valid) begin
            acc <= acc + tree_sum;
        end
    end

    // The drain counter runs until the last beat has left the accumulator.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            value     <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (vec_len != '0) begin
                            len_q    <= vec_len;
                            beat_cnt <= '0;
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end else begin
                            value     <= '0;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == len_q - LEN_W'(1)) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYC)) begin
                        value     <= acc;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: hand-computed sums, latency,
// output hold, zero-length commands, mid-run reset and ignored restarts.
module tb_dot_product_engine;

    localparam int PIXEL_SIZE  = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int VAL_SIZE    = 26;
    localparam int PARALLEL    = 2;
    localparam int MUL_LAT     = 2;
    localparam int LEN_W       = 8;
    localparam int LAT         = MUL_LAT + 3;

    logic                            clk = 1'b0;
    logic                            GlobalReset;
    logic                            start;
    logic [LEN_W-1:0]                vec_len;
    logic                            in_valid;
    logic                            in_ready;
    logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels;
    logic [PARALLEL*WEIGHT_SIZE-1:0] Weights;
    logic                            out_valid;
    logic                            out_ready;
    logic [VAL_SIZE-1:0]             value;
    logic                            busy;

    logic [PARALLEL*PIXEL_SIZE-1:0]  pix_tab [8];
    logic [PARALLEL*WEIGHT_SIZE-1:0] wt_tab  [8];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    dot_product_engine #(
        .PIXEL_SIZE (PIXEL_SIZE),
        .WEIGHT_SIZE(WEIGHT_SIZE),
        .VAL_SIZE   (VAL_SIZE),
        .PARALLEL   (PARALLEL),
        .MUL_LAT    (MUL_LAT),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .start      (start),
        .vec_len    (vec_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Pixels     (Pixels),
        .Weights    (Weights),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .value      (value),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset;
        GlobalReset = 1'b1;
        repeat (2) @(negedge clk);
        GlobalReset = 1'b0;
    endtask

    // ---------------- drivers ----------------
    // Feeds n beats from pix_tab/wt_tab; returns the cycle index of the last
    // accepting edge. start_at>=0 pulses start with vec_len=6 on that step.
    task automatic run_beats(input int n, input bit gaps, input int start_at, output int acc_cyc);
        int sent;
        int t;
        sent = 0;
        t = 0;
        acc_cyc = -1;
        while (sent < n && t < 100) begin
            in_valid = !(gaps && (t % 2 == 1));
            Pixels   = pix_tab[sent];
            Weights  = wt_tab[sent];
            if (t == start_at) begin
                start   = 1'b1;
                vec_len = 8'd6;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) begin
                sent++;
                acc_cyc = cyc + 1;
            end
            t++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (sent != n) begin
            failures++;
            $display("FAIL beats_accepted got=%0d exp=%0d", sent, n);
        end
    endtask

    task automatic wait_out(output bit found, output int seen_cyc);
        found = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                found = 1'b1;
                seen_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue_cmd(input logic [LEN_W-1:0] len);
        start = 1'b1;
        vec_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (value !== 26'd0) begin failures++; $display("FAIL reset_value got=%0h exp=0", value); end
    endtask

    task automatic test_basic;
        int acc_cyc;
        int seen;
        bit found;
        out_ready = 1'b0;
        issue_cmd(8'd3);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_run_entry busy=%0b in_ready=%0b exp=1,1", busy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            pix_tab[i] = {10'd1, 10'd1};
            wt_tab[i]  = {19'd2, 19'd2};
        end
        run_beats(3, 1'b0, -1, acc_cyc);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_drain_in_ready got=%0b exp=0", in_ready); end
        wait_out(found, seen);
        checks++;
        if (!found) begin failures++; $display("FAIL basic_out_timeout got=0 exp=1"); end
        checks++;
        if (seen - acc_cyc != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", seen - acc_cyc, LAT); end
        checks++;
        if (value !== 26'd12) begin failures++; $display("FAIL basic_value got=%0h exp=%0h", value, 26'd12); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_out got=%0b exp=1", busy); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_after_handshake out_valid=%0b busy=%0b exp=0,0", out_valid, busy);
        end
        checks++;
        if (value !== 26'd12) begin failures++; $display("FAIL basic_value_held got=%0h exp=%0h", value, 26'd12); end
    endtask

    task automatic test_wrap;
        int acc_cyc;
        int seen;
        bit found;
        out_ready = 1'b1;
        issue_cmd(8'd1);
        pix_tab[0] = {10'd1023, 10'd1023};
        wt_tab[0]  = {19'h7FFFF, 19'h7FFFF};
        run_beats(1, 1'b0, -1, acc_cyc);
        wait_out(found, seen);
        checks++;
        if (!found) begin failures++; $display("FAIL wrap_out_timeout got=0 exp=1"); end
        checks++;
        if (seen - acc_cyc != LAT) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", seen - acc_cyc, LAT); end
        checks++;
        if (value !== 26'h3FFF802) begin failures++; $display("FAIL wrap_value got=%0h exp=%0h", value, 26'h3FFF802); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL wrap_one_cycle_out out_valid=%0b busy=%0b exp=0,0", out_valid, busy);
        end
    endtask

    task automatic test_zero_len;
        out_ready = 1'b0;
        issue_cmd(8'd0);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL zero_out_entry out_valid=%0b busy=%0b exp=1,1", out_valid, busy);
        end
        checks++;
        if (value !== 26'd0) begin failures++; $display("FAIL zero_value got=%0h exp=0", value); end
        start = 1'b1;
        vec_len = 8'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL zero_start_ignored out_valid=%0b in_ready=%0b exp=1,0", out_valid, in_ready);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_idle out_valid=%0b busy=%0b exp=0,0", out_valid, busy);
        end
    endtask

    task automatic test_gaps;
        int acc_cyc;
        int seen;
        bit found;
        out_ready = 1'b0;
        issue_cmd(8'd4);
        for (int i = 0; i < 4; i++) begin
            pix_tab[i] = {10'(i + 1), 10'(i + 1)};
            wt_tab[i]  = {19'd1, 19'd1};
        end
        run_beats(4, 1'b1, -1, acc_cyc);
        wait_out(found, seen);
        checks++;
        if (!found) begin failures++; $display("FAIL gaps_out_timeout got=0 exp=1"); end
        checks++;
        if (seen - acc_cyc != LAT) begin failures++; $display("FAIL gaps_latency got=%0d exp=%0d", seen - acc_cyc, LAT); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || value !== 26'd20) begin
                failures++;
                $display("FAIL gaps_hold cycle=%0d out_valid=%0b busy=%0b value=%0h exp=1,1,14", i, out_valid, busy, value);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL gaps_release out_valid=%0b busy=%0b exp=0,0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        int acc_cyc;
        int seen;
        bit found;
        out_ready = 1'b0;
        issue_cmd(8'd5);
        for (int i = 0; i < 2; i++) begin
            pix_tab[i] = {10'd7, 10'd7};
            wt_tab[i]  = {19'd9, 19'd9};
        end
        run_beats(2, 1'b0, -1, acc_cyc);
        GlobalReset = 1'b1;
        @(negedge clk);
        GlobalReset = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl busy=%0b in_ready=%0b out_valid=%0b exp=0,0,0", busy, in_ready, out_valid);
        end
        checks++;
        if (value !== 26'd0) begin failures++; $display("FAIL midreset_value got=%0h exp=0", value); end
        out_ready = 1'b1;
        issue_cmd(8'd1);
        pix_tab[0] = {10'd1, 10'd1};
        wt_tab[0]  = {19'd1, 19'd1};
        run_beats(1, 1'b0, -1, acc_cyc);
        wait_out(found, seen);
        checks++;
        if (!found) begin failures++; $display("FAIL midreset_out_timeout got=0 exp=1"); end
        checks++;
        if (value !== 26'd2) begin failures++; $display("FAIL midreset_fresh_value got=%0h exp=2", value); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acc_cyc;
        int seen;
        bit found;
        out_ready = 1'b0;
        issue_cmd(8'd3);
        for (int i = 0; i < 3; i++) begin
            pix_tab[i] = {10'd4, 10'd3};
            wt_tab[i]  = {19'h7FFFE, 19'd5};
        end
        run_beats(3, 1'b0, 1, acc_cyc);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL restart_len_kept in_ready=%0b exp=0", in_ready); end
        wait_out(found, seen);
        checks++;
        if (!found) begin failures++; $display("FAIL restart_out_timeout got=0 exp=1"); end
        checks++;
        if (seen - acc_cyc != LAT) begin failures++; $display("FAIL restart_latency got=%0d exp=%0d", seen - acc_cyc, LAT); end
        checks++;
        if (value !== 26'd21) begin failures++; $display("FAIL restart_value got=%0h exp=%0h", value, 26'd21); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL restart_idle busy=%0b exp=0", busy); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        GlobalReset = 1'b1;
        start       = 1'b0;
        vec_len     = '0;
        in_valid    = 1'b0;
        Pixels      = '0;
        Weights     = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
